// File: rtl/axi_lite_apb_req_bridge_pkg.sv
// rtl/axi_lite_apb_req_bridge_pkg.sv - shared types, response codes and arbitration helper for the bridge
package axi_lite_apb_req_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_WR_RSP = 3'd3,
        ST_RD_RSP = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

    // Contention alternates away from the previous grant; a lone requester always wins.
    function automatic grant_e arbitrate(input logic wr_pend, input logic rd_pend,
                                         input grant_e last_grant);
        if (wr_pend && rd_pend) begin
            return (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
        end
        return wr_pend ? GRANT_WR : GRANT_RD;
    endfunction

endpackage

// File: rtl/axi_lite_apb_req_bridge_if.sv
// rtl/axi_lite_apb_req_bridge_if.sv - AXI4-Lite slave bus and single-request port interfaces
interface axi_lite_if
    import axi_lite_apb_req_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    localparam int STRB_W = DATA_W / 8;

    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid;
    logic              s_wready;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_bvalid;
    logic              s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid;
    logic              s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
    );
endinterface

interface req_if
    import axi_lite_apb_req_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic [DATA_W-1:0] req_rdata;
    logic              req_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, req_rdata, req_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, req_rdata, req_error
    );
endinterface

// File: rtl/axi_lite_hold_reg.sv
// rtl/axi_lite_hold_reg.sv - one-entry capture register for an AXI4-Lite channel
module axi_lite_hold_reg
    import axi_lite_apb_req_bridge_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] payload,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    assign ready = !full;

    // Capture on handshake; the consumer empties the entry once the request has completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (valid && !full) begin
            full <= 1'b1;
            data <= payload;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_apb_req_bridge.sv
// rtl/axi_lite_apb_req_bridge.sv - AXI4-Lite slave that serialises reads and writes onto a single request port
module axi_lite_apb_req_bridge
    import axi_lite_apb_req_bridge_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter bit STRICT_STRB = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_lite_if.slave  s_axi,
    req_if.master      req
);

    localparam int STRB_W = DATA_W / 8;

    logic                     aw_full;
    logic                     w_full;
    logic                     ar_full;
    logic [ADDR_W-1:0]        aw_addr;
    logic [ADDR_W-1:0]        ar_addr;
    logic [STRB_W+DATA_W-1:0] w_hold;
    logic [STRB_W-1:0]        w_strb;
    logic [DATA_W-1:0]        w_data;

    logic                     clear_wr;
    logic                     clear_rd;
    logic                     wr_pend;
    logic                     rd_pend;
    logic                     wr_grant;
    logic                     rd_grant;
    logic                     strb_bad;
    logic                     strb_reject;

    state_e                   state;
    state_e                   state_next;
    grant_e                   last_grant;
    grant_e                   grant;
    logic                     resp_err;
    logic [DATA_W-1:0]        rdata_q;

    axi_lite_hold_reg #(.WIDTH(ADDR_W)) u_aw_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (s_axi.s_awvalid),
        .ready   (s_axi.s_awready),
        .payload (s_axi.s_awaddr),
        .clear   (clear_wr),
        .full    (aw_full),
        .data    (aw_addr)
    );

    axi_lite_hold_reg #(.WIDTH(STRB_W + DATA_W)) u_w_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (s_axi.s_wvalid),
        .ready   (s_axi.s_wready),
        .payload ({s_axi.s_wstrb, s_axi.s_wdata}),
        .clear   (clear_wr),
        .full    (w_full),
        .data    (w_hold)
    );

    axi_lite_hold_reg #(.WIDTH(ADDR_W)) u_ar_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (s_axi.s_arvalid),
        .ready   (s_axi.s_arready),
        .payload (s_axi.s_araddr),
        .clear   (clear_rd),
        .full    (ar_full),
        .data    (ar_addr)
    );

    assign w_strb      = w_hold[STRB_W+DATA_W-1:DATA_W];
    assign w_data      = w_hold[DATA_W-1:0];
    assign wr_pend     = aw_full && w_full;
    assign rd_pend     = ar_full;
    assign grant       = arbitrate(wr_pend, rd_pend, last_grant);
    assign wr_grant    = wr_pend && (grant == GRANT_WR);
    assign rd_grant    = rd_pend && (grant == GRANT_RD);
    assign strb_bad    = STRICT_STRB && (w_strb != {STRB_W{1'b1}});
    // A partial-strobe write is answered locally and never reaches the request port.
    assign strb_reject = (state == ST_IDLE) && wr_grant && strb_bad;

    // State register; reset abandons any in-flight request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: grant in IDLE, wait for completion pulse, then wait for response acceptance.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (strb_reject) begin
                    state_next = ST_WR_RSP;
                end else if (wr_grant) begin
                    state_next = ST_WR_REQ;
                end else if (rd_grant) begin
                    state_next = ST_RD_REQ;
                end
            end
            ST_WR_REQ: if (req.req_ready)     state_next = ST_WR_RSP;
            ST_RD_REQ: if (req.req_ready)     state_next = ST_RD_RSP;
            ST_WR_RSP: if (s_axi.s_bready)    state_next = ST_IDLE;
            ST_RD_RSP: if (s_axi.s_rready)    state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    // Outputs and hold-register release, decoded from the current state.
    always_comb begin
        req.req_valid  = 1'b0;
        req.req_write  = 1'b0;
        req.req_addr   = '0;
        req.req_wdata  = '0;
        s_axi.s_bvalid = 1'b0;
        s_axi.s_bresp  = RESP_OKAY;
        s_axi.s_rvalid = 1'b0;
        s_axi.s_rresp  = RESP_OKAY;
        s_axi.s_rdata  = '0;
        clear_wr       = 1'b0;
        clear_rd       = 1'b0;
        case (state)
            ST_IDLE: begin
                clear_wr = strb_reject;
            end
            ST_WR_REQ: begin
                req.req_valid = 1'b1;
                req.req_write = 1'b1;
                req.req_addr  = aw_addr;
                req.req_wdata = w_data;
                clear_wr      = req.req_ready;
            end
            ST_RD_REQ: begin
                req.req_valid = 1'b1;
                req.req_addr  = ar_addr;
                clear_rd      = req.req_ready;
            end
            ST_WR_RSP: begin
                s_axi.s_bvalid = 1'b1;
                s_axi.s_bresp  = resp_err ? RESP_SLVERR : RESP_OKAY;
            end
            ST_RD_RSP: begin
                s_axi.s_rvalid = 1'b1;
                s_axi.s_rresp  = resp_err ? RESP_SLVERR : RESP_OKAY;
                s_axi.s_rdata  = rdata_q;
            end
            default: begin
            end
        endcase
    end

    // Completion results and the arbitration history that steers the next contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_RD;
            resp_err   <= 1'b0;
            rdata_q    <= '0;
        end else if (strb_reject) begin
            last_grant <= GRANT_WR;
            resp_err   <= 1'b1;
        end else if ((state == ST_WR_REQ) && req.req_ready) begin
            last_grant <= GRANT_WR;
            resp_err   <= req.req_error;
        end else if ((state == ST_RD_REQ) && req.req_ready) begin
            last_grant <= GRANT_RD;
            resp_err   <= req.req_error;
            rdata_q    <= req.req_rdata;
        end
    end

endmodule

// File: tb/tb_axi_lite_apb_req_bridge.sv
// tb/tb_axi_lite_apb_req_bridge.sv - self-checking bench for axi_lite_apb_req_bridge
module tb_axi_lite_apb_req_bridge;
    import axi_lite_apb_req_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();
    req_if      #(.ADDR_W(32), .DATA_W(32)) rq ();

    axi_lite_apb_req_bridge #(.ADDR_W(32), .DATA_W(32), .STRICT_STRB(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (axi),
        .req   (rq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    req_t        log_q[$];
    int          rsp_delay = 0;
    logic        rsp_err   = 1'b0;
    logic [31:0] rsp_rdata = '0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request responder: logs each request, checks it stays stable, answers after rsp_delay cycles.
    initial begin : responder
        int   cnt;
        bit   busy;
        req_t cur;
        busy = 0;
        cnt  = 0;
        rq.req_ready = 1'b0;
        rq.req_rdata = '0;
        rq.req_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                busy = 0;
                rq.req_ready = 1'b0;
            end else if (rq.req_ready) begin
                rq.req_ready = 1'b0;
                chk("req_drop_after_ready", rq.req_valid, 0);
                chk("rsp_valid_next_cycle", axi.s_bvalid | axi.s_rvalid, 1);
            end else if (rq.req_valid) begin
                if (!busy) begin
                    busy = 1;
                    cnt  = rsp_delay;
                    cur  = '{rq.req_write, rq.req_addr, rq.req_wdata};
                    log_q.push_back(cur);
                end else begin
                    chk("req_stable", {rq.req_write, rq.req_addr, rq.req_wdata},
                        {cur.wr, cur.addr, cur.wdata});
                end
                if (cnt == 0) begin
                    rq.req_ready = 1'b1;
                    rq.req_rdata = rsp_rdata;
                    rq.req_error = rsp_err;
                    busy = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_aw(input logic [31:0] a);
        axi.s_awvalid = 1'b1;
        axi.s_awaddr  = a;
        for (int i = 0; i < 200 && !axi.s_awready; i++) cyc(1);
        chk("aw_accept", axi.s_awready, 1);
        cyc(1);
        axi.s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        axi.s_wvalid = 1'b1;
        axi.s_wdata  = d;
        axi.s_wstrb  = s;
        for (int i = 0; i < 200 && !axi.s_wready; i++) cyc(1);
        chk("w_accept", axi.s_wready, 1);
        cyc(1);
        axi.s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        axi.s_arvalid = 1'b1;
        axi.s_araddr  = a;
        for (int i = 0; i < 200 && !axi.s_arready; i++) cyc(1);
        chk("ar_accept", axi.s_arready, 1);
        cyc(1);
        axi.s_arvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] exp_resp, input int stall);
        axi.s_bready = 1'b0;
        for (int i = 0; i < 200 && !axi.s_bvalid; i++) cyc(1);
        chk("bvalid_seen", axi.s_bvalid, 1);
        for (int i = 0; i < stall; i++) begin
            chk("b_hold_valid", axi.s_bvalid, 1);
            chk("b_hold_resp", axi.s_bresp, exp_resp);
            chk("no_req_during_b", rq.req_valid, 0);
            cyc(1);
        end
        chk("bresp", axi.s_bresp, exp_resp);
        axi.s_bready = 1'b1;
        cyc(1);
        axi.s_bready = 1'b0;
        chk("b_done", axi.s_bvalid, 0);
    endtask

    task automatic wait_r(input logic [31:0] exp_data, input logic [1:0] exp_resp, input int stall);
        axi.s_rready = 1'b0;
        for (int i = 0; i < 200 && !axi.s_rvalid; i++) cyc(1);
        chk("rvalid_seen", axi.s_rvalid, 1);
        for (int i = 0; i < stall; i++) begin
            chk("r_hold_data", axi.s_rdata, exp_data);
            cyc(1);
        end
        chk("rdata", axi.s_rdata, exp_data);
        chk("rresp", axi.s_rresp, exp_resp);
        axi.s_rready = 1'b1;
        cyc(1);
        axi.s_rready = 1'b0;
        chk("r_done", axi.s_rvalid, 0);
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < 300; i++) begin
            if (log_q.size() == n && !rq.req_valid && !rq.req_ready &&
                !axi.s_bvalid && !axi.s_rvalid) break;
            cyc(1);
        end
        chk("req_count", log_q.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin : main
        bit          m_last_wr;
        bit          exp_first_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  exp_resp;
        int          sk_aw;
        int          sk_w;

        axi.s_awvalid = 1'b0; axi.s_awaddr = '0;
        axi.s_wvalid  = 1'b0; axi.s_wdata  = '0; axi.s_wstrb = '0;
        axi.s_bready  = 1'b0;
        axi.s_arvalid = 1'b0; axi.s_araddr = '0;
        axi.s_rready  = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_req_valid", rq.req_valid, 0);
        chk("rst_bvalid", axi.s_bvalid, 0);
        chk("rst_rvalid", axi.s_rvalid, 0);
        chk("rst_rdata", axi.s_rdata, 0);
        chk("rst_awready", axi.s_awready, 1);
        chk("rst_wready", axi.s_wready, 1);
        chk("rst_arready", axi.s_arready, 1);
        rst_n = 1'b1;
        cyc(1);

        // 1: simple write
        rsp_delay = 2; rsp_err = 1'b0;
        fork
            send_aw(32'h0000_0004);
            send_w(32'h0000_00A5, 4'hF);
        join
        wait_b(RESP_OKAY, 0);
        wait_idle(1);
        chk("t1_write", log_q[0].wr, 1);
        chk("t1_addr", log_q[0].addr, 32'h4);
        chk("t1_wdata", log_q[0].wdata, 32'hA5);

        // 2: W three cycles ahead of AW, latency T+2
        log_q.delete();
        rsp_delay = 1;
        send_w(32'h0000_0011, 4'hF);
        chk("t2_wready_low", axi.s_wready, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_no_req_before_aw", rq.req_valid, 0);
            cyc(1);
        end
        send_aw(32'h0000_0008);
        chk("t2_req_not_at_t1", rq.req_valid, 0);
        cyc(1);
        chk("t2_req_at_t2", rq.req_valid, 1);
        chk("t2_req_addr", rq.req_addr, 32'h8);
        chk("t2_req_wdata", rq.req_wdata, 32'h11);
        wait_b(RESP_OKAY, 0);
        wait_idle(1);

        // 3: read with error
        log_q.delete();
        rsp_rdata = 32'hDEAD_BEEF; rsp_err = 1'b1;
        send_ar(32'h1000_0000);
        wait_r(32'hDEAD_BEEF, RESP_SLVERR, 0);
        wait_idle(1);
        chk("t3_write", log_q[0].wr, 0);
        chk("t3_addr", log_q[0].addr, 32'h1000_0000);

        // 4: contention order follows alternation from last grant
        do_reset();
        m_last_wr = 0;
        rsp_delay = 1; rsp_err = 1'b0; rsp_rdata = 32'h1234_5678;
        log_q.delete();
        axi.s_bready = 1'b1; axi.s_rready = 1'b1;
        fork
            send_aw(32'h100); send_w(32'h1, 4'hF); send_ar(32'h200);
        join
        wait_idle(2);
        exp_first_wr = !m_last_wr;
        chk("t4a_first", log_q[0].wr, exp_first_wr);
        chk("t4a_second", log_q[1].wr, !exp_first_wr);
        m_last_wr = !exp_first_wr;
        log_q.delete();
        fork send_aw(32'h104); send_w(32'h2, 4'hF); join
        wait_idle(1);
        m_last_wr = 1;
        log_q.delete();
        fork
            send_aw(32'h108); send_w(32'h3, 4'hF); send_ar(32'h20C);
        join
        wait_idle(2);
        exp_first_wr = !m_last_wr;
        chk("t4b_first", log_q[0].wr, exp_first_wr);
        chk("t4b_second", log_q[1].wr, !exp_first_wr);
        axi.s_bready = 1'b0; axi.s_rready = 1'b0;

        // 5: partial strobe rejected locally
        log_q.delete();
        fork send_aw(32'h20); send_w(32'h5555_5555, 4'h3); join
        wait_b(RESP_SLVERR, 0);
        wait_idle(0);

        // 6: B stalled while the next write is captured
        log_q.delete();
        rsp_delay = 0; rsp_err = 1'b0;
        fork send_aw(32'h30); send_w(32'h77, 4'hF); join
        fork
            wait_b(RESP_OKAY, 5);
            begin cyc(1); fork send_aw(32'h34); send_w(32'h88, 4'hF); join end
        join
        wait_b(RESP_OKAY, 0);
        wait_idle(2);
        chk("t6_second_addr", log_q[1].addr, 32'h34);
        chk("t6_second_wdata", log_q[1].wdata, 32'h88);

        // 6b: reset while a request is outstanding
        rsp_delay = 20;
        fork send_aw(32'h40); send_w(32'h1, 4'hF); join
        for (int i = 0; i < 20 && !rq.req_valid; i++) cyc(1);
        chk("t6b_req_up", rq.req_valid, 1);
        send_ar(32'h50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6b_req_drop", rq.req_valid, 0);
        chk("t6b_awready", axi.s_awready, 1);
        chk("t6b_wready", axi.s_wready, 1);
        chk("t6b_arready", axi.s_arready, 1);
        chk("t6b_bvalid", axi.s_bvalid, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Random traffic against the transaction-level model
        for (int it = 0; it < 24; it++) begin
            log_q.delete();
            rsp_delay = $urandom_range(0, 3);
            rsp_err   = 1'($urandom_range(0, 1));
            rsp_rdata = $urandom;
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                sk_aw = $urandom_range(0, 3);
                sk_w  = $urandom_range(0, 3);
                fork
                    begin cyc(sk_aw); send_aw(a); end
                    begin cyc(sk_w); send_w(d, s); end
                join
                exp_resp = (s != 4'hF || rsp_err) ? RESP_SLVERR : RESP_OKAY;
                wait_b(exp_resp, $urandom_range(0, 2));
                wait_idle((s == 4'hF) ? 1 : 0);
                if (s == 4'hF) begin
                    chk("rnd_wr_req", {log_q[0].wr, log_q[0].addr, log_q[0].wdata}, {1'b1, a, d});
                end
            end else begin
                send_ar(a);
                wait_r(rsp_rdata, rsp_err ? RESP_SLVERR : RESP_OKAY, $urandom_range(0, 2));
                wait_idle(1);
                chk("rnd_rd_req", {log_q[0].wr, log_q[0].addr}, {1'b0, a});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
